// File: rtl/irq_capture_4x2.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : irq_capture_4x2
// Description : Four-line interrupt capture. Each request line is synchronised,
//               captured into a pending register (rising-edge sticky or level
//               following, per line), and the highest-index enabled pending
//               request is presented as a 2-bit code with a valid/ready
//               handshake. Edges arriving on already-pending lines are flagged
//               in a sticky lost vector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module irq_capture_4x2 #(
   parameter int         SYNC_STAGES = 2,       // synchroniser depth, 2..4
   parameter logic [3:0] EDGE_MASK   = 4'b1111  // 1 = edge sticky, 0 = level
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_req_in,
   input  logic [3:0] i_mask,
   output logic [1:0] o_code,
   output logic       o_valid,
   input  logic       i_ready,
   output logic [3:0] o_pending,
   output logic [3:0] o_lost,
   input  logic       i_clr_lost
);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PRESENT = 1'b1
   } state_t;

   logic [3:0] r_sync [SYNC_STAGES];
   logic [3:0] r_sync_d;
   logic [3:0] r_pending;
   logic [3:0] r_lost;
   logic [1:0] r_code;
   logic       r_valid;
   state_t     r_state;

   logic [3:0] w_sync_q;
   logic [3:0] w_rise;
   logic       w_accept;
   logic [3:0] w_clr;
   logic [3:0] w_eligible;
   logic [1:0] w_top_idx;
   logic [3:0] w_pending_nxt;
   logic [3:0] w_lost_nxt;

   assign w_sync_q = r_sync[SYNC_STAGES-1];
   // r_sync_d resets to 0, so a line already high at reset release yields one rise.
   assign w_rise   = w_sync_q & ~r_sync_d & EDGE_MASK;
   assign w_accept = r_valid & i_ready;
   assign w_clr    = w_accept ? (4'b0001 << r_code) : 4'b0000;

   // Synchroniser chain plus one delayed copy of its output for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= 4'b0000;
         end
         r_sync_d <= 4'b0000;
      end else begin
         r_sync[0] <= i_req_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_sync_d <= w_sync_q;
      end
   end

   // Next pending/lost: edge bits are set by a rise (set beats accept-clear);
   // level bits simply track the synchronised line.
   always_comb begin
      w_pending_nxt = (EDGE_MASK & (w_rise | (r_pending & ~w_clr)))
                    | (~EDGE_MASK & w_sync_q);
      w_lost_nxt    = (i_clr_lost ? 4'b0000 : r_lost)
                    | (w_rise & r_pending & ~w_clr);
   end

   // Pending and lost registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= 4'b0000;
         r_lost    <= 4'b0000;
      end else begin
         r_pending <= w_pending_nxt;
         r_lost    <= w_lost_nxt;
      end
   end

   // Highest-index enabled pending request (bit 3 has top priority).
   always_comb begin
      w_eligible = r_pending & i_mask;
      w_top_idx  = 2'd0;
      if (w_eligible[3]) begin
         w_top_idx = 2'd3;
      end else if (w_eligible[2]) begin
         w_top_idx = 2'd2;
      end else if (w_eligible[1]) begin
         w_top_idx = 2'd1;
      end
   end

   // Grant FSM: latch a code in IDLE, hold it until accepted; the return to
   // IDLE guarantees a one-cycle bubble between grants.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_code  <= 2'd0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_eligible != 4'b0000) begin
                  r_code  <= w_top_idx;
                  r_valid <= 1'b1;
                  r_state <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (i_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_code    = r_code;
   assign o_valid   = r_valid;
   assign o_pending = r_pending;
   assign o_lost    = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_irq_capture_4x2.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_irq_capture_4x2
// Description : Bench for irq_capture_4x2. Two instances (all-edge and bit0
//               level) share stimulus and are compared every cycle against a
//               behavioural model, plus directed checks of the key scenarios.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_irq_capture_4x2;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] msk;
   logic       rdy;
   logic       clrl;

   logic [1:0] ca, cb;
   logic       va, vb;
   logic [3:0] pa, pb, la, lb;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model state, index 0 = dut_a, 1 = dut_b
   logic [3:0] hist[$];
   logic [3:0] em     [2] = '{4'b1111, 4'b1110};
   logic [3:0] m_pend [2];
   logic [3:0] m_lost [2];
   logic       m_valid[2];
   logic [1:0] m_code [2];

   always #5 clk = ~clk;

   irq_capture_4x2 #(.SYNC_STAGES(S), .EDGE_MASK(4'b1111)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_req_in(req), .i_mask(msk),
      .o_code(ca), .o_valid(va), .i_ready(rdy),
      .o_pending(pa), .o_lost(la), .i_clr_lost(clrl));

   irq_capture_4x2 #(.SYNC_STAGES(S), .EDGE_MASK(4'b1110)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_req_in(req), .i_mask(msk),
      .o_code(cb), .o_valid(vb), .i_ready(rdy),
      .o_pending(pb), .o_lost(lb), .i_clr_lost(clrl));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied, clock
   // the DUTs, then compare full output state of both instances.
   task automatic step();
      logic [3:0] sq, sd, rise, clr, elig, np, nl;
      sq = hist[S-1];
      sd = hist[S];
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_pend[i] = 4'b0; m_lost[i] = 4'b0; m_valid[i] = 1'b0; m_code[i] = 2'd0;
         end else begin
            rise = 4'b0;
            clr  = 4'b0;
            for (int b = 0; b < 4; b++) begin
               if (em[i][b] && sq[b] && !sd[b]) rise[b] = 1'b1;
            end
            if (m_valid[i] && rdy) clr[m_code[i]] = 1'b1;
            nl = clrl ? 4'b0 : m_lost[i];
            for (int b = 0; b < 4; b++) begin
               if (!em[i][b])     np[b] = sq[b];
               else if (rise[b])  np[b] = 1'b1;
               else if (clr[b])   np[b] = 1'b0;
               else               np[b] = m_pend[i][b];
               if (rise[b] && m_pend[i][b] && !clr[b]) nl[b] = 1'b1;
            end
            if (m_valid[i]) begin
               if (rdy) m_valid[i] = 1'b0;
            end else begin
               elig = m_pend[i] & msk;
               for (int b = 0; b < 4; b++) begin
                  if (elig[b]) m_code[i] = 2'(b);
               end
               if (elig != 4'b0) m_valid[i] = 1'b1;
            end
            m_pend[i] = np;
            m_lost[i] = nl;
         end
      end
      if (!rst_n) begin
         for (int k = 0; k <= S; k++) hist[k] = 4'b0;
      end else begin
         hist.push_front(req);
         void'(hist.pop_back());
      end
      @(posedge clk);
      #1;
      chk("model_a {pend,lost,valid,code}", {pa, la, va, ca},
          {m_pend[0], m_lost[0], m_valid[0], m_code[0]});
      chk("model_b {pend,lost,valid,code}", {pb, lb, vb, cb},
          {m_pend[1], m_lost[1], m_valid[1], m_code[1]});
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      logic [1:0] got[$];
      int         grants;
      int         waited;

      for (int k = 0; k <= S; k++) hist.push_back(4'b0);
      for (int i = 0; i < 2; i++) begin
         m_pend[i] = 4'b0; m_lost[i] = 4'b0; m_valid[i] = 1'b0; m_code[i] = 2'd0;
      end
      rst_n = 1'b0; req = 4'b0; msk = 4'hF; rdy = 1'b1; clrl = 1'b0;
      #2;

      // 1: reset state, ready held high with nothing pending
      steps(3);
      chk("reset_valid", va, 1'b0);
      chk("reset_pending", pa, 4'b0);
      rst_n = 1'b1;
      steps(4);
      chk("idle_ready_valid", va, 1'b0);

      // 2: single edge pulse on bit 2, latency and hold
      rdy = 1'b0;
      req = 4'b0100;
      step();
      req = 4'b0000;
      steps(2);
      chk("t2_pending_lat", pa, 4'b0100);
      chk("t2_valid_early", va, 1'b0);
      step();
      chk("t2_valid", va, 1'b1);
      chk("t2_code", ca, 2'd2);
      steps(3);
      chk("t2_hold_code", {va, ca}, {1'b1, 2'd2});
      rdy = 1'b1;
      step();
      chk("t2_accept", {va, pa}, {1'b0, 4'b0000});

      // 3: simultaneous pulses, drained in priority order with bubbles
      req = 4'b1011;
      step();
      req = 4'b0000;
      for (int k = 0; k < 14; k++) begin
         step();
         if (va) got.push_back(ca);
      end
      chk("t3_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("t3_first", got[0], 2'd3);
         chk("t3_second", got[1], 2'd1);
         chk("t3_third", got[2], 2'd0);
      end
      chk("t3_pending_end", pa, 4'b0);

      // 4: masked top request, unmasking mid-present does not alter code
      rdy = 1'b0; msk = 4'b0111;
      req = 4'b1001;
      step();
      req = 4'b0000;
      steps(5);
      chk("t4_code0", {va, ca}, {1'b1, 2'd0});
      msk = 4'b1111;
      steps(2);
      chk("t4_code_stable", {va, ca}, {1'b1, 2'd0});
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      step();
      chk("t4_next_code3", {va, ca}, {1'b1, 2'd3});
      rdy = 1'b1;
      steps(3);

      // 5: lost flag, clear, and clear colliding with a new loss
      msk = 4'b0000; rdy = 1'b0;
      req = 4'b0010; step(); req = 4'b0000; steps(4);
      chk("t5_pending1", pa, 4'b0010);
      req = 4'b0010; step(); req = 4'b0000; steps(4);
      chk("t5_lost", la, 4'b0010);
      clrl = 1'b1; step(); clrl = 1'b0;
      chk("t5_lost_clr", la, 4'b0000);
      req = 4'b0010; step(); req = 4'b0000; step();
      clrl = 1'b1; step(); clrl = 1'b0;
      chk("t5_lost_wins", la, 4'b0010);
      msk = 4'hF; rdy = 1'b1; clrl = 1'b1; step(); clrl = 1'b0;
      steps(6);

      // 6: level bit 0 on dut_b re-presented after every accept
      req = 4'b0001;
      grants = 0;
      for (int k = 0; k < 14; k++) begin
         step();
         if (vb && cb == 2'd0) grants++;
      end
      chk("t6_level_regrant", grants >= 4, 1'b1);
      rdy = 1'b0;
      waited = 0;
      while (!vb && waited < 10) begin
         step();
         waited++;
      end
      chk("t6_wait_valid", vb, 1'b1);
      req = 4'b0000;
      steps(4);
      chk("t6_no_retract", {vb, cb}, {1'b1, 2'd0});
      rdy = 1'b1;
      step();
      chk("t6_complete", vb, 1'b0);
      grants = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (vb) grants++;
      end
      chk("t6_no_new_valid", grants, 0);

      // 6b: reset while presenting discards the grant
      rdy = 1'b0; req = 4'b1000;
      steps(6);
      chk("t6_present_a", va, 1'b1);
      chk("t6_present_b", vb, 1'b1);
      rst_n = 1'b0;
      step();
      chk("t6_rst_valid", {va, vb}, 2'b00);
      chk("t6_rst_pending", {pa, pb}, 8'h00);
      rst_n = 1'b1; req = 4'b0000;
      steps(2);

      // Random phase against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         if ($urandom_range(0, 7) == 0) msk = 4'($urandom);
         rdy   = 1'($urandom_range(0, 1));
         clrl  = ($urandom_range(0, 15) == 0);
         rst_n = ($urandom_range(0, 99) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
